// File: rtl/divider_pkg.sv
// Shared constants and FSM encoding for the histogram-equalisation divider.
package divider_pkg;

   localparam int DEF_DATA_W       = 16;
   localparam int DEF_OUT_W        = 8;
   localparam int DEF_LEVELS_MAX   = 255;
   localparam int DEF_TOTAL_PIXELS = 16384;
   localparam int DEF_NUM_W        = DEF_DATA_W + DEF_OUT_W;
   localparam int DEF_CNT_W        = $clog2(DEF_NUM_W + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CALC = 2'd2,
      ST_DONE = 2'd3
   } div_state_e;

endpackage : divider_pkg

// File: rtl/div_restoring_step.sv
// One combinational restoring-division iteration: shift in a numerator bit, subtract if it fits.
module div_restoring_step #(
   parameter int DEN_W = 17
) (
   input  logic [DEN_W-1:0] rem_i,
   input  logic             num_msb_i,
   input  logic [DEN_W-1:0] den_i,
   output logic [DEN_W-1:0] rem_o,
   output logic             q_bit_o
);

   logic [DEN_W:0]   trial_s;
   logic [DEN_W-1:0] diff_s;

   // The subtracted remainder is always below den, so DEN_W bits hold it exactly.
   always_comb begin
      trial_s = {rem_i, num_msb_i};
      diff_s  = trial_s[DEN_W-1:0] - den_i;
      if (trial_s >= {1'b0, den_i}) begin
         rem_o   = diff_s;
         q_bit_o = 1'b1;
      end else begin
         rem_o   = trial_s[DEN_W-1:0];
         q_bit_o = 1'b0;
      end
   end

endmodule : div_restoring_step

// File: rtl/divider_scale_unit.sv
// Sequential equalisation divider: ((cdf - cdf_min) * LEVELS_MAX) / (TOTAL_PIXELS - cdf_min).
// Define DIVIDER_ROUND_EN for round-to-nearest instead of truncation (same latency).
module divider_scale_unit
   import divider_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int OUT_W        = DEF_OUT_W,
   parameter int LEVELS_MAX   = DEF_LEVELS_MAX,
   parameter int TOTAL_PIXELS = DEF_TOTAL_PIXELS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              sc_mem_rd_done,
   input  logic [DATA_W-1:0] rd_data1,
   input  logic [DATA_W-1:0] rd_data2,
   output logic              div_done,
   output logic [OUT_W-1:0]  div_quotient,
   output logic              div_busy
);

   localparam int NUM_W = DATA_W + OUT_W;
   localparam int DEN_W = DATA_W + 1;
   localparam int CNT_W = $clog2(NUM_W + 1);

   localparam logic [NUM_W-1:0] LEVELS_NUM = NUM_W'(LEVELS_MAX);
   localparam logic [DEN_W-1:0] TOTAL_DEN  = DEN_W'(TOTAL_PIXELS);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(NUM_W - 1);

   div_state_e        state_q;
   logic [DATA_W-1:0] cdf_q;
   logic [DATA_W-1:0] cdf_min_q;
   logic [NUM_W-1:0]  num_q;
   logic [DEN_W-1:0]  den_q;
   logic [DEN_W-1:0]  rem_q;
   logic [NUM_W-1:0]  quo_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [NUM_W-1:0]  num_d;
   logic [DEN_W-1:0]  den_d;
   logic [DEN_W-1:0]  rem_step_s;
   logic              q_bit_s;
   logic [NUM_W-1:0]  quo_next_s;

   function automatic logic [OUT_W-1:0] sat_level(input logic [NUM_W-1:0] q);
      if (q > LEVELS_NUM) begin
         return LEVELS_NUM[OUT_W-1:0];
      end else begin
         return q[OUT_W-1:0];
      end
   endfunction

   // Numerator and denominator derived from the captured operands, registered in LOAD.
   always_comb begin
      num_d = {NUM_W{1'b0}};
      den_d = TOTAL_DEN - {1'b0, cdf_min_q};
      if (cdf_q > cdf_min_q) begin
         num_d = NUM_W'(cdf_q - cdf_min_q) * LEVELS_NUM;
      end else begin
         num_d = {NUM_W{1'b0}};
      end
`ifdef DIVIDER_ROUND_EN
      if ((den_d != {DEN_W{1'b0}}) && (num_d != {NUM_W{1'b0}})) begin
         num_d = num_d + NUM_W'(den_d >> 1);
      end else begin
         num_d = num_d;
      end
`endif
   end

   div_restoring_step #(
      .DEN_W (DEN_W)
   ) u_step (
      .rem_i     (rem_q),
      .num_msb_i (num_q[NUM_W-1]),
      .den_i     (den_q),
      .rem_o     (rem_step_s),
      .q_bit_o   (q_bit_s)
   );

   assign quo_next_s = {quo_q[NUM_W-2:0], q_bit_s};

   // Control FSM with registered outputs; the numerator shifts out MSB-first during CALC.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cdf_q        <= {DATA_W{1'b0}};
         cdf_min_q    <= {DATA_W{1'b0}};
         num_q        <= {NUM_W{1'b0}};
         den_q        <= {DEN_W{1'b0}};
         rem_q        <= {DEN_W{1'b0}};
         quo_q        <= {NUM_W{1'b0}};
         cnt_q        <= {CNT_W{1'b0}};
         div_done     <= 1'b0;
         div_busy     <= 1'b0;
         div_quotient <= {OUT_W{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               div_done <= 1'b0;
               div_busy <= 1'b0;
               if (enable && sc_mem_rd_done) begin
                  cdf_q     <= rd_data1;
                  cdf_min_q <= rd_data2;
                  div_busy  <= 1'b1;
                  state_q   <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               num_q <= num_d;
               den_q <= den_d;
               rem_q <= {DEN_W{1'b0}};
               quo_q <= {NUM_W{1'b0}};
               cnt_q <= {CNT_W{1'b0}};
               if (den_d == {DEN_W{1'b0}}) begin
                  div_quotient <= {OUT_W{1'b0}};
                  div_done     <= 1'b1;
                  state_q      <= ST_DONE;
               end else begin
                  state_q <= ST_CALC;
               end
            end
            ST_CALC: begin
               rem_q <= rem_step_s;
               num_q <= num_q << 1;
               quo_q <= quo_next_s;
               cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               if (cnt_q == CNT_LAST) begin
                  div_quotient <= sat_level(quo_next_s);
                  div_done     <= 1'b1;
                  state_q      <= ST_DONE;
               end
            end
            ST_DONE: begin
               div_done <= 1'b0;
               div_busy <= 1'b0;
               state_q  <= ST_IDLE;
            end
            default: begin
               div_done <= 1'b0;
               div_busy <= 1'b0;
               state_q  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : divider_scale_unit

// File: doc/divider_scale_unit.md
# divider_scale_unit

Sequential histogram-equalisation divider: the downstream consumer of the scratch-memory controller. On each operand handshake it takes a CDF value and the CDF minimum read from scratch memory, computes the equalised grey level ((cdf − cdf_min) × LEVELS_MAX) / (TOTAL_PIXELS − cdf_min) with a restoring divider, and returns the 8-bit result. It pulses `div_done` to tell the controller that the result is ready for write-back and that the next read may start.

## Interface
- `DATA_W`, 16: width of CDF operands.
- `OUT_W`, 8: width of the result.
- `LEVELS_MAX`, 255: scale factor, equal to 2^OUT_W − 1.
- `TOTAL_PIXELS`, 16384: pixel count of the image; the denominator base.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `enable`  in  1: level; new operations start only while high.
- `sc_mem_rd_done`  in  1: operands valid on `rd_data1`/`rd_data2` this cycle.
- `rd_data1`  in  DATA_W: CDF value.
- `rd_data2`  in  DATA_W: CDF minimum.
- `div_done`  out  1: one-cycle pulse, result valid.
- `div_quotient`  out  OUT_W: equalised level, registered.
- `div_busy`  out  1: high in LOAD, CALC and DONE.

## Operation
- FSM states: IDLE, LOAD, CALC, DONE.
- IDLE→LOAD when `enable && sc_mem_rd_done`. Operands are captured on that edge.
- LOAD:
  - num = (cdf > cdf_min) ? (cdf − cdf_min) × LEVELS_MAX : 0, width NUM_W = DATA_W + OUT_W = 24.
  - den = TOTAL_PIXELS − cdf_min, width DATA_W + 1.
  - den == 0 → DONE with result 0. Otherwise → CALC, iteration counter = 0, remainder = 0.
- CALC:
  - Each edge does one restoring step: shift the remainder left, bring in the numerator MSB, subtract den if it is ≥ den, and set the quotient bit.
  - After NUM_W = 24 steps → DONE.
- DONE:
  - `div_quotient` = min(quotient, LEVELS_MAX), loaded on entry to DONE.
  - `div_done` = 1 for this single cycle.
  - Next edge → IDLE.
- `sc_mem_rd_done` outside IDLE is ignored. Operands are not re-captured.
- `enable` falling mid-operation does not abort the operation.
- Reset values: state IDLE, `div_done` 0, `div_busy` 0, `div_quotient` 0, all internal registers 0.
- Reset in any state, including mid-CALC, returns to IDLE. No `div_done` is emitted for the aborted operation.

## Timing
- Edge numbering: edge 0 is the edge that samples the handshake (IDLE→LOAD).
- Normal path: LOAD→CALC at edge 1, iterations at edges 2–25, DONE entered at edge 25. `div_done` is high between edges 25 and 26.
- Zero-denominator path: DONE entered at edge 1; `div_done` is high between edges 1 and 2.
- Earliest next capture: IDLE at edge 26 (normal path), so a new handshake can be sampled at edge 27 or later. Handshakes arriving earlier are ignored.
- `div_quotient` holds its value until the next DONE entry or reset.

## Configuration
- `DIVIDER_ROUND_EN` defined: LOAD adds floor(den/2) to num (only when den ≠ 0 and num ≠ 0), giving round-to-nearest. Saturation to LEVELS_MAX still applies.
- `DIVIDER_ROUND_EN` undefined: truncating division.
- Latency is identical in both builds.

## Structure
- Package `divider_pkg`:
  - FSM state encoding.
  - NUM_W derivation.
  - LEVELS_MAX default.
  - Iteration-counter width, $clog2(NUM_W + 1).
- Sub-module `div_restoring_step`: combinational single iteration. Inputs: remainder, numerator MSB, den. Outputs: next remainder, quotient bit.
- Top level holds the FSM, the operand and num/den registers, the counter and the saturation logic.

## Test plan
- cdf=16384, cdf_min=0 → `div_quotient`=255; `div_done` is a one-cycle pulse entered at edge 25; `div_busy` is high for edges 1–25.
- cdf=8192, cdf_min=0 → 127 when truncating; 128 with `DIVIDER_ROUND_EN`.
- cdf=100, cdf_min=200 → 0 with the full 25-edge latency. cdf=300, cdf_min=200, den=16184 → 1 truncating, 2 rounded.
- cdf_min=16384 (den=0) → 0, `div_done` between edges 1 and 2, no CALC cycles.
- `reset` at edge 10 mid-CALC → no `div_done`, `div_quotient`=0. A following handshake with cdf=16384, cdf_min=0 completes normally with 255.
- `sc_mem_rd_done` pulsed at edges 5 and 20 of an active operation, and also pulsed while `enable`=0 in IDLE → all ignored. The original result and latency are unchanged, and exactly one `div_done` pulse occurs.
